// File: rtl/voice_control_regfile_if.sv
// ---------------------------------------------------------------------------
// voice_control_regfile_if
// AXI4-Lite bus bundle between the PS interconnect (master) and the voice
// control register file (slave).
//   AW channel : AWADDR, AWPROT, AWVALID, AWREADY
//   W  channel : WDATA, WSTRB, WVALID, WREADY
//   B  channel : BRESP, BVALID, BREADY
//   AR channel : ARADDR, ARPROT, ARVALID, ARREADY
//   R  channel : RDATA, RRESP, RVALID, RREADY
// ---------------------------------------------------------------------------
interface voice_control_regfile_if #(
   parameter int ADDR_W = 8
) ();
   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [31:0]       WDATA;
   logic [3:0]        WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              ARVALID;
   logic              ARREADY;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/voice_control_regfile.sv
// ---------------------------------------------------------------------------
// voice_control_regfile
// AXI4-Lite register slave holding per-voice synth controls.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   s_axi         : AXI4-Lite slave bus (voice_control_regfile_if.slave)
//   phase_inc     : per-voice phase increment, voice v at [v*PHASE_W +: PHASE_W]
//   gate          : per-voice level gate
//   note_on/off   : one-cycle pulses on gate rising/falling edges
//   waveform      : 3 bits per voice
//   velocity      : 8 bits per voice
//   env_adsr      : 32 bits per voice {release,sustain,decay,attack}
// Map: block 0 = ID / GATE_STATUS / ALL_OFF / SCRATCH; block v+1 = voice v
// (PHASE_INC / CTRL / ENV / reserved). Blocks past the last voice -> SLVERR.
// ---------------------------------------------------------------------------
module voice_control_regfile #(
   parameter int          NUM_VOICES = 8,
   parameter int          PHASE_W    = 24,
   parameter int          ADDR_W     = 8,
   parameter logic [31:0] VERSION    = 32'h0002_0000
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   voice_control_regfile_if.slave        s_axi,
   output logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
   output logic [NUM_VOICES-1:0]         gate,
   output logic [NUM_VOICES-1:0]         note_on,
   output logic [NUM_VOICES-1:0]         note_off,
   output logic [3*NUM_VOICES-1:0]       waveform,
   output logic [8*NUM_VOICES-1:0]       velocity,
   output logic [32*NUM_VOICES-1:0]      env_adsr
);
   localparam int         BLK_W       = ADDR_W - 4;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Byte-lane merge of new data over an old word.
   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int n = 0; n < 4; n++) begin
         res[8*n +: 8] = strb[n] ? new_v[8*n +: 8] : old_v[8*n +: 8];
      end
      return res;
   endfunction

   logic              r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
   logic [ADDR_W-1:0] r_aw_addr;
   logic [31:0]       r_w_data;
   logic [3:0]        r_w_strb;
   logic [1:0]        r_bresp;
   logic              r_arready, r_ar_held, r_rvalid;
   logic [ADDR_W-1:0] r_ar_addr;
   logic [31:0]       r_rdata;
   logic [1:0]        r_rresp;

   logic [31:0]        r_scratch;
   logic [PHASE_W-1:0] r_phase [NUM_VOICES];
   logic [2:0]         r_wave  [NUM_VOICES];
   logic [7:0]         r_vel   [NUM_VOICES];
   logic [31:0]        r_env   [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_gate, r_note_on, r_note_off;

   logic w_aw_acc, w_w_acc, w_commit, w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt;
   logic w_ar_acc, w_rvalid_nxt, w_wr_ok, w_rd_ok;
   logic [BLK_W-1:0] w_wblk, w_rblk;
   logic [1:0]       w_woff, w_roff;
   logic [31:0]      w_rd_data, w_gword, w_vword;
   logic [NUM_VOICES-1:0] w_gate_nxt;
   logic w_unused_ok;

   // Handshake bookkeeping: a write commits on the edge both slots are already full.
   always_comb begin
      w_aw_acc      = s_axi.AWVALID & r_awready;
      w_w_acc       = s_axi.WVALID & r_wready;
      w_commit      = r_aw_held & r_w_held;
      w_aw_held_nxt = !w_commit && (r_aw_held || w_aw_acc);
      w_w_held_nxt  = !w_commit && (r_w_held || w_w_acc);
      w_bvalid_nxt  = w_commit || (r_bvalid && !s_axi.BREADY);
      w_ar_acc      = s_axi.ARVALID & r_arready;
      w_rvalid_nxt  = r_ar_held || (r_rvalid && !s_axi.RREADY);
      w_wblk        = r_aw_addr[ADDR_W-1:4];
      w_woff        = r_aw_addr[3:2];
      w_rblk        = r_ar_addr[ADDR_W-1:4];
      w_roff        = r_ar_addr[3:2];
      w_wr_ok       = (w_wblk <= BLK_W'(NUM_VOICES));
      w_rd_ok       = (w_rblk <= BLK_W'(NUM_VOICES));
      w_unused_ok   = &{1'b0, s_axi.AWPROT, s_axi.ARPROT,
                        r_aw_addr[1:0], r_ar_addr[1:0]};
   end

   // Next gate vector: ALL_OFF clears everything, CTRL byte 0 sets one voice.
   always_comb begin
      w_gate_nxt = r_gate;
      if (w_commit && w_wr_ok && (w_wblk == {BLK_W{1'b0}}) && (w_woff == 2'd2)
          && r_w_strb[0] && r_w_data[0]) begin
         w_gate_nxt = {NUM_VOICES{1'b0}};
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            w_gate_nxt[v] = (w_commit && (w_wblk == BLK_W'(v + 1)) &&
                             (w_woff == 2'd1) && r_w_strb[0]) ? r_w_data[0] : r_gate[v];
         end
      end
   end

   // Read mux over the held read address; unmatched addresses read 0.
   always_comb begin
      w_vword = 32'h0;
      case (w_roff)
         2'd0:    w_gword = VERSION;
         2'd1:    w_gword = 32'(r_gate);
         2'd3:    w_gword = r_scratch;
         default: w_gword = 32'h0;
      endcase
      w_rd_data = (w_rblk == {BLK_W{1'b0}}) ? w_gword : 32'h0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         case (w_roff)
            2'd0:    w_vword = 32'(r_phase[v]);
            2'd1:    w_vword = {16'h0, r_vel[v], 4'h0, r_wave[v], r_gate[v]};
            2'd2:    w_vword = r_env[v];
            default: w_vword = 32'h0;
         endcase
         w_rd_data = w_rd_data | ((w_rblk == BLK_W'(v + 1)) ? w_vword : 32'h0);
      end
   end

   // Write channel: independent AW/W holding slots and the B response.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_addr <= {ADDR_W{1'b0}};
         r_w_data  <= 32'h0;
         r_w_strb  <= 4'h0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_aw_held <= w_aw_held_nxt;
         r_w_held  <= w_w_held_nxt;
         if (w_aw_acc) r_aw_addr <= s_axi.AWADDR;
         if (w_w_acc) begin
            r_w_data <= s_axi.WDATA;
            r_w_strb <= s_axi.WSTRB;
         end
         r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
         r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
         r_bvalid  <= w_bvalid_nxt;
         if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Read channel: AR is held one edge, the response is produced on the next.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_ar_held <= 1'b0;
         r_ar_addr <= {ADDR_W{1'b0}};
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'h0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_ar_held <= w_ar_acc;
         if (w_ar_acc) r_ar_addr <= s_axi.ARADDR;
         r_rvalid  <= w_rvalid_nxt;
         r_arready <= !w_ar_acc && !w_rvalid_nxt;
         if (r_ar_held) begin
            r_rdata <= w_rd_ok ? w_rd_data : 32'h0;
            r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Register storage and gate edge pulses.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_scratch  <= 32'h0;
         r_gate     <= {NUM_VOICES{1'b0}};
         r_note_on  <= {NUM_VOICES{1'b0}};
         r_note_off <= {NUM_VOICES{1'b0}};
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_phase[v] <= {PHASE_W{1'b0}};
            r_wave[v]  <= 3'h0;
            r_vel[v]   <= 8'h0;
            r_env[v]   <= 32'h0;
         end
      end else begin
         r_gate     <= w_gate_nxt;
         r_note_on  <= w_gate_nxt & ~r_gate;
         r_note_off <= ~w_gate_nxt & r_gate;
         if (w_commit && w_wr_ok) begin
            if ((w_wblk == {BLK_W{1'b0}}) && (w_woff == 2'd3)) begin
               r_scratch <= strb_merge(r_scratch, r_w_data, r_w_strb);
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (w_wblk == BLK_W'(v + 1)) begin
                  case (w_woff)
                     2'd0: r_phase[v] <= PHASE_W'(strb_merge(32'(r_phase[v]), r_w_data, r_w_strb));
                     2'd1: begin
                        if (r_w_strb[0]) r_wave[v] <= r_w_data[3:1];
                        if (r_w_strb[1]) r_vel[v]  <= r_w_data[15:8];
                     end
                     2'd2:    r_env[v] <= strb_merge(r_env[v], r_w_data, r_w_strb);
                     default: r_env[v] <= r_env[v];
                  endcase
               end
            end
         end
      end
   end

   assign s_axi.AWREADY = r_awready;
   assign s_axi.WREADY  = r_wready;
   assign s_axi.BVALID  = r_bvalid;
   assign s_axi.BRESP   = r_bresp;
   assign s_axi.ARREADY = r_arready;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = r_rresp;
   assign gate          = r_gate;
   assign note_on       = r_note_on;
   assign note_off      = r_note_off;

   for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_pack
      assign phase_inc[gv*PHASE_W +: PHASE_W] = r_phase[gv];
      assign waveform[3*gv +: 3]              = r_wave[gv];
      assign velocity[8*gv +: 8]              = r_vel[gv];
      assign env_adsr[32*gv +: 32]            = r_env[gv];
   end
endmodule

// File: tb/tb_voice_control_regfile.sv
module tb_voice_control_regfile;
   localparam int          NV  = 8;
   localparam int          PW  = 24;
   localparam int          AW  = 8;
   localparam logic [31:0] VER = 32'h0002_0000;

   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   always #5 ACLK = ~ACLK;

   voice_control_regfile_if #(.ADDR_W(AW)) bus ();

   logic [NV*PW-1:0] phase_inc;
   logic [NV-1:0]    gate, note_on, note_off;
   logic [3*NV-1:0]  waveform;
   logic [8*NV-1:0]  velocity;
   logic [32*NV-1:0] env_adsr;

   voice_control_regfile #(.NUM_VOICES(NV), .PHASE_W(PW), .ADDR_W(AW), .VERSION(VER)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus),
      .phase_inc(phase_inc), .gate(gate), .note_on(note_on), .note_off(note_off),
      .waveform(waveform), .velocity(velocity), .env_adsr(env_adsr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: one 32-bit word per address, masked to its stored fields.
   logic [31:0] m_reg [(NV+1)*4];

   function automatic logic [31:0] fld_mask(input int widx);
      int blk, off;
      blk = widx / 4;
      off = widx % 4;
      if (blk == 0) return (off == 3) ? 32'hFFFF_FFFF : 32'h0;
      case (off)
         0:       return (32'h1 << PW) - 32'h1;
         1:       return 32'h0000_FF0F;
         2:       return 32'hFFFF_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [NV-1:0] model_gates();
      logic [NV-1:0] g;
      for (int v = 0; v < NV; v++) g[v] = m_reg[(v+1)*4+1][0];
      return g;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      int w;
      w = int'(a) / 4;
      if (int'(a) >= 16*(NV+1)) return 32'h0;
      if (w == 0) return VER;
      if (w == 1) return 32'(model_gates());
      return m_reg[w];
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      logic [31:0] merged;
      w = int'(a) / 4;
      if (int'(a) < 16*(NV+1)) begin
         if (w == 2) begin
            if (s[0] && d[0])
               for (int v = 0; v < NV; v++) m_reg[(v+1)*4+1][0] = 1'b0;
         end else begin
            merged = m_reg[w];
            for (int n = 0; n < 4; n++) if (s[n]) merged[8*n +: 8] = d[8*n +: 8];
            m_reg[w] = merged & fld_mask(w);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ":gate"}, 64'(gate), 64'(model_gates()));
      for (int v = 0; v < NV; v++) begin
         check_val($sformatf("%s:phase%0d", tag, v), 64'(phase_inc[v*PW +: PW]), 64'(m_reg[(v+1)*4][PW-1:0]));
         check_val($sformatf("%s:wave%0d", tag, v), 64'(waveform[3*v +: 3]), 64'(m_reg[(v+1)*4+1][3:1]));
         check_val($sformatf("%s:vel%0d", tag, v), 64'(velocity[8*v +: 8]), 64'(m_reg[(v+1)*4+1][15:8]));
         check_val($sformatf("%s:env%0d", tag, v), 64'(env_adsr[32*v +: 32]), 64'(m_reg[(v+1)*4+2]));
      end
   endtask

   logic [NV-1:0] p_on0, p_off0, p_on1, p_off1;

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      bit aw_ok, w_ok, a_now, w_now, b_ok;
      @(negedge ACLK);
      bus.AWADDR = a; bus.AWVALID = 1'b1;
      bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
      aw_ok = 1'b0; w_ok = 1'b0; n = 0;
      while (!(aw_ok && w_ok) && n < 50) begin
         a_now = bus.AWVALID && bus.AWREADY;
         w_now = bus.WVALID && bus.WREADY;
         @(posedge ACLK); #1;
         if (a_now) begin bus.AWVALID = 1'b0; aw_ok = 1'b1; end
         if (w_now) begin bus.WVALID = 1'b0; w_ok = 1'b1; end
         n++;
         if (!(aw_ok && w_ok)) @(negedge ACLK);
      end
      check_val("wr_addr_data_handshake", 64'(aw_ok && w_ok), 64'd1);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      b_ok = 1'b0; n = 0;
      while (!b_ok && n < 50) begin
         @(negedge ACLK);
         if (bus.BVALID) b_ok = 1'b1;
         n++;
      end
      check_val("wr_bvalid_seen", 64'(b_ok), 64'd1);
      resp = bus.BRESP; p_on0 = note_on; p_off0 = note_off;
      bus.BREADY = 1'b1;
      @(posedge ACLK); #1;
      bus.BREADY = 1'b0;
      @(negedge ACLK);
      p_on1 = note_on; p_off1 = note_off;
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      bit ok;
      @(negedge ACLK);
      bus.ARADDR = a; bus.ARVALID = 1'b1;
      ok = 1'b0; n = 0;
      while (!ok && n < 50) begin
         if (bus.ARREADY) ok = 1'b1;
         @(posedge ACLK); #1;
         n++;
         if (ok) bus.ARVALID = 1'b0;
         else @(negedge ACLK);
      end
      check_val("rd_ar_handshake", 64'(ok), 64'd1);
      bus.ARVALID = 1'b0;
      ok = 1'b0; n = 0;
      while (!ok && n < 50) begin
         @(negedge ACLK);
         if (bus.RVALID) ok = 1'b1;
         n++;
      end
      check_val("rd_rvalid_seen", 64'(ok), 64'd1);
      d = bus.RDATA; resp = bus.RRESP;
      bus.RREADY = 1'b1;
      @(posedge ACLK); #1;
      bus.RREADY = 1'b0;
   endtask

   // Model-checked write: response plus note pulses on the commit cycle and after.
   task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [NV-1:0] g0, g1;
      logic [1:0] resp;
      g0 = model_gates();
      model_write(a, d, s);
      g1 = model_gates();
      axi_write(a, d, s, resp);
      check_val({tag, ":bresp"}, 64'(resp), (int'(a) >= 16*(NV+1)) ? 64'd2 : 64'd0);
      check_val({tag, ":note_on"}, 64'(p_on0), 64'(g1 & ~g0));
      check_val({tag, ":note_off"}, 64'(p_off0), 64'(g0 & ~g1));
      check_val({tag, ":pulse_end"}, 64'({p_on1, p_off1}), 64'd0);
   endtask

   task automatic do_read(input string tag, input logic [7:0] a);
      logic [31:0] d;
      logic [1:0] resp;
      axi_read(a, d, resp);
      check_val({tag, ":rdata"}, 64'(d), 64'(model_read(a)));
      check_val({tag, ":rresp"}, 64'(resp), (int'(a) >= 16*(NV+1)) ? 64'd2 : 64'd0);
   endtask

   initial begin
      logic [7:0]  ra;
      logic [31:0] rd;
      logic [1:0]  rr;
      for (int i = 0; i < (NV+1)*4; i++) m_reg[i] = 32'h0;
      bus.AWADDR = 8'h0; bus.AWPROT = 3'h0; bus.AWVALID = 1'b0;
      bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
      bus.ARADDR = 8'h0; bus.ARPROT = 3'h0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

      repeat (3) @(negedge ACLK);
      check_val("rst:readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'd0);
      check_val("rst:valids", 64'({bus.BVALID, bus.RVALID}), 64'd0);
      check_val("rst:pulses", 64'({note_on, note_off}), 64'd0);
      check_outputs("rst");
      ARESETN = 1'b1;
      @(negedge ACLK);
      check_val("rst:ready_after_release", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);

      do_read("id", 8'h00);
      do_read("gate_status0", 8'h04);
      axi_read(8'h00, rd, rr);
      check_val("id_const", 64'(rd), 64'h0002_0000);

      do_write("phase0", 8'h10, 32'h0123_4567, 4'hF);
      axi_read(8'h10, rd, rr);
      check_val("phase0_rd_const", 64'(rd), 64'h0023_4567);
      check_val("phase0_out_const", 64'(phase_inc[23:0]), 64'h23_4567);

      do_write("ctrl2", 8'h34, 32'h0000_7F05, 4'hF);
      check_val("ctrl2_on_const", 64'(p_on0), 64'h04);
      check_val("ctrl2_wave_const", 64'(waveform[8:6]), 64'h2);
      check_val("ctrl2_vel_const", 64'(velocity[23:16]), 64'h7F);
      do_write("ctrl2_again", 8'h34, 32'h0000_7F05, 4'hF);
      check_val("ctrl2_again_on_const", 64'(p_on0), 64'h0);
      do_read("ctrl2_rd", 8'h34);

      // Split AW then W with B held off for four cycles.
      @(negedge ACLK);
      bus.AWADDR = 8'h28; bus.AWVALID = 1'b1;
      check_val("bp:awready_idle", 64'(bus.AWREADY), 64'd1);
      @(posedge ACLK); #1; bus.AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge ACLK);
         check_val("bp:aw_held", 64'({bus.AWREADY, bus.WREADY, bus.BVALID}), 64'b010);
      end
      @(negedge ACLK);
      bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      check_val("bp:wready", 64'(bus.WREADY), 64'd1);
      @(posedge ACLK); #1; bus.WVALID = 1'b0;
      @(negedge ACLK);
      check_val("bp:before_commit", 64'({bus.AWREADY, bus.WREADY, bus.BVALID}), 64'b000);
      model_write(8'h28, 32'hCAFE_F00D, 4'hF);
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         check_val("bp:b_hold", 64'({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP}), 64'b00100);
      end
      bus.BREADY = 1'b1;
      @(posedge ACLK); #1; bus.BREADY = 1'b0;
      @(negedge ACLK);
      check_val("bp:b_done", 64'({bus.AWREADY, bus.WREADY, bus.BVALID}), 64'b110);
      do_read("bp_rd", 8'h28);

      do_write("ctrl2_off", 8'h34, 32'h0000_7F04, 4'hF);
      do_write("gate0", 8'h14, 32'h1, 4'hF);
      do_write("gate3", 8'h44, 32'h1, 4'hF);
      do_write("gate7", 8'h84, 32'h1, 4'hF);
      do_read("gates_on", 8'h04);
      do_write("all_off", 8'h08, 32'h1, 4'h1);
      check_val("all_off_const", 64'(p_off0), 64'h89);
      do_read("gates_cleared", 8'h04);

      do_write("oob_wr", 8'h90, 32'hDEAD_BEEF, 4'hF);
      do_read("oob_rd", 8'h90);
      axi_read(8'h90, rd, rr);
      check_val("oob_rd_const", 64'({rr, rd}), 64'h2_0000_0000);

      do_write("env0_strb", 8'h18, 32'hAABB_CCDD, 4'b0010);
      axi_read(8'h18, rd, rr);
      check_val("env0_strb_const", 64'(rd), 64'h0000_CC00);
      check_outputs("directed");

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) ra = 8'($urandom_range(0, 255)) & 8'hFC;
         else ra = 8'($urandom_range(0, 4*(NV+1)-1) << 2);
         if ($urandom_range(0, 1) == 0) do_write("rnd_wr", ra, $urandom, 4'($urandom_range(0, 15)));
         else do_read("rnd_rd", ra);
         if (i % 25 == 24) check_outputs("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
